// File: rtl/vppm_avg_pkg.sv
// Shared types and helpers for the VPPM window averager: FSM states,
// accumulator width calculation and signed saturation limits.
package vppm_avg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic int unsigned calc_aw(input int unsigned dw, input int unsigned cw);
        return dw + cw;
    endfunction

    function automatic longint sat_hi(input int unsigned dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int unsigned dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    localparam int unsigned DEF_DW     = 16;
    localparam longint      DEF_RES_HI = sat_hi(DEF_DW);
    localparam longint      DEF_RES_LO = sat_lo(DEF_DW);

endpackage

// File: rtl/vppm_avg_seq_div.sv
// Unsigned restoring divider: AW-bit dividend, CW-bit divisor, one quotient
// bit per cycle, done pulses exactly AW cycles after the start edge.
module vppm_seq_div #(
    parameter int AW = 29,
    parameter int CW = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [AW-1:0] dividend_i,
    input  logic [CW-1:0] divisor_i,
    output logic [AW-1:0] quotient_o,
    output logic          done_o
);

    localparam int KW = $clog2(AW + 1);

    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] dvs_q, dvs_d;
    logic [AW-1:0] quo_q, quo_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;
    logic [CW:0]   shift_s;
    logic [CW:0]   diff_s;

    // Next-state for one restoring step per cycle
    always_comb begin
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_d  = 1'b0;
        shift_s = {rem_q, quo_q[AW-1]};
        diff_s  = shift_s - {1'b0, dvs_q};
        if (start_i) begin
            rem_d = {CW{1'b0}};
            dvs_d = divisor_i;
            quo_d = dividend_i;
            cnt_d = KW'(AW);
            run_d = 1'b1;
        end else if (run_q) begin
            if (shift_s >= {1'b0, dvs_q}) begin
                rem_d = diff_s[CW-1:0];
                quo_d = {quo_q[AW-2:0], 1'b1};
            end else begin
                rem_d = shift_s[CW-1:0];
                quo_d = {quo_q[AW-2:0], 1'b0};
            end
            cnt_d = cnt_q - KW'(1);
            if (cnt_q == KW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                run_d  = 1'b1;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Divider state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= {CW{1'b0}};
            dvs_q  <= {CW{1'b0}};
            quo_q  <= {AW{1'b0}};
            cnt_q  <= {KW{1'b0}};
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/vppm_window_avg.sv
// Windowed, decimated signed averager producing one mean per frame.
// Build option: define VPPM_AVG_ROUND_EN for round-half-away-from-zero.
module vppm_window_avg
    import vppm_avg_pkg::*;
#(
    parameter int DW        = 16,
    parameter int CW        = 13,
    parameter int SKIP      = 96,
    parameter int FRAME_LEN = 4096,
    parameter int DECIM     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [CW-1:0] in_count,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          frame_abort,
    output logic          busy
);

    localparam int AW = calc_aw(DW, CW);
    localparam logic [CW-1:0]        SKIP_C   = CW'(SKIP);
    localparam logic [CW-1:0]        LAST_CNT = CW'(FRAME_LEN - 1);
    localparam logic [3:0]           PH_LAST  = 4'(DECIM - 1);
    localparam logic [3:0]           PH_FIRST = (DECIM == 1) ? 4'd0 : 4'd1;
    localparam logic signed [AW:0]   RES_HI   = (AW+1)'(sat_hi(DW));
    localparam logic signed [AW:0]   RES_LO   = (AW+1)'(sat_lo(DW));

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        n_q, n_d;
    logic [3:0]           phase_q, phase_d;
    logic [CW-1:0]        prev_cnt_q, prev_cnt_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 abort_q, abort_d;
    logic                 busy_q, busy_d;
    logic                 started_q, started_d;

    logic signed [AW-1:0] data_ext_s;
    logic [3:0]           phase_nxt_s;
    logic                 acc_neg_s;
    logic [AW-1:0]        acc_abs_s;
    logic [AW-1:0]        dividend_s;
    logic [AW-1:0]        quo_s;
    logic                 div_start_s;
    logic                 div_done_s;
    logic signed [AW:0]   quo_signed_s;
    logic [DW-1:0]        result_s;

    vppm_seq_div #(
        .AW (AW),
        .CW (CW)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start_s),
        .dividend_i (dividend_s),
        .divisor_i  (n_q),
        .quotient_o (quo_s),
        .done_o     (div_done_s)
    );

    // Magnitude path: divide |acc| (optionally biased by n/2), reapply sign, saturate
    always_comb begin
        acc_neg_s = acc_q[AW-1];
        acc_abs_s = acc_neg_s ? $unsigned(-acc_q) : $unsigned(acc_q);
`ifdef VPPM_AVG_ROUND_EN
        dividend_s = acc_abs_s + AW'(n_q >> 1);
`else
        dividend_s = acc_abs_s;
`endif
        quo_signed_s = acc_neg_s ? -$signed({1'b0, quo_s}) : $signed({1'b0, quo_s});
        if (n_q == {CW{1'b0}}) begin
            result_s = {DW{1'b0}};
        end else if (quo_signed_s > RES_HI) begin
            result_s = RES_HI[DW-1:0];
        end else if (quo_signed_s < RES_LO) begin
            result_s = RES_LO[DW-1:0];
        end else begin
            result_s = quo_signed_s[DW-1:0];
        end
    end

    // Frame FSM and accumulator next-state
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        n_d         = n_q;
        phase_d     = phase_q;
        prev_cnt_d  = prev_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        abort_d     = 1'b0;
        started_d   = started_q;
        div_start_s = 1'b0;
        data_ext_s  = {{CW{in_data[DW-1]}}, in_data};
        phase_nxt_s = (phase_q == PH_LAST) ? 4'd0 : phase_q + 4'd1;
        case (state_q)
            IDLE: begin
                acc_d     = {AW{1'b0}};
                n_d       = {CW{1'b0}};
                phase_d   = 4'd0;
                started_d = 1'b0;
                if (in_valid && (in_count > SKIP_C)) begin
                    acc_d      = data_ext_s;
                    n_d        = CW'(1);
                    phase_d    = PH_FIRST;
                    prev_cnt_d = in_count;
                    state_d    = (in_count == LAST_CNT) ? DIV : ACC;
                end else begin
                    state_d    = IDLE;
                end
            end
            ACC: begin
                if (in_valid) begin
                    prev_cnt_d = in_count;
                    // A non-increasing count means the front end restarted the frame
                    if (in_count <= prev_cnt_q) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                        acc_d   = {AW{1'b0}};
                        n_d     = {CW{1'b0}};
                        phase_d = 4'd0;
                    end else begin
                        if (phase_q == 4'd0) begin
                            acc_d = acc_q + data_ext_s;
                            n_d   = n_q + CW'(1);
                        end else begin
                            acc_d = acc_q;
                        end
                        phase_d = phase_nxt_s;
                        state_d = (in_count == LAST_CNT) ? DIV : ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            DIV: begin
                if (!started_q) begin
                    div_start_s = 1'b1;
                    started_d   = 1'b1;
                end else if (div_done_s) begin
                    out_data_d  = result_s;
                    out_valid_d = 1'b1;
                    started_d   = 1'b0;
                    state_d     = HOLD;
                end else begin
                    state_d     = DIV;
                end
            end
            HOLD: begin
                if (in_valid && (in_count == {CW{1'b0}})) begin
                    state_d = IDLE;
                    acc_d   = {AW{1'b0}};
                    n_d     = {CW{1'b0}};
                    phase_d = 4'd0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == ACC) || (state_d == DIV);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= {AW{1'b0}};
            n_q         <= {CW{1'b0}};
            phase_q     <= 4'd0;
            prev_cnt_q  <= {CW{1'b0}};
            out_data_q  <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            n_q         <= n_d;
            phase_q     <= phase_d;
            prev_cnt_q  <= prev_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            started_q   <= started_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_abort = abort_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vppm_window_avg.sv
// Directed self-checking bench for vppm_window_avg (default instance plus a
// short-frame instance with SKIP=0, FRAME_LEN=4, DECIM=1).
module tb_vppm_window_avg;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [12:0]        in_count;
    logic [15:0]        in_data;
    logic [15:0]        out_data;
    logic               out_valid;
    logic               frame_abort;
    logic               busy;

    logic               s_in_valid;
    logic [12:0]        s_in_count;
    logic [15:0]        s_in_data;
    logic [15:0]        s_out_data;
    logic               s_out_valid;
    logic               s_frame_abort;
    logic               s_busy;

    int n_assert = 0;
    int n_fail   = 0;

    vppm_window_avg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_count    (in_count),
        .in_data     (in_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    vppm_window_avg #(
        .SKIP      (0),
        .FRAME_LEN (4),
        .DECIM     (1)
    ) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (s_in_valid),
        .in_count    (s_in_count),
        .in_data     (s_in_data),
        .out_data    (s_out_data),
        .out_valid   (s_out_valid),
        .frame_abort (s_frame_abort),
        .busy        (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input int c, input int d);
        in_valid = v;
        in_count = 13'(c);
        in_data  = 16'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int mode, input int val);
        for (int c = 0; c < 4096; c++) begin
            cyc(1'b1, c, (mode == 0) ? val : (c - 2096));
        end
    endtask

    // Called just after the edge that sampled count 4095
    task automatic wait_result(input string tag, input int exp);
        int lat;
        lat = 0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'sd1);
        for (int k = 1; (k <= 40) && (lat == 0); k++) begin
            cyc(1'b0, 0, 0);
            if (out_valid) lat = k;
        end
        chk({tag, "_latency"}, lat, 32'sd31);
        chk({tag, "_data"}, $signed(out_data), exp);
        chk({tag, "_busy_off"}, {31'd0, busy}, 32'sd0);
        cyc(1'b0, 0, 0);
        chk({tag, "_pulse"}, {31'd0, out_valid}, 32'sd0);
    endtask

    initial begin
        int lat;
        int pulses;
        int c;
        int exp_small;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_count   = 13'd0;
        in_data    = 16'd0;
        s_in_valid = 1'b0;
        s_in_count = 13'd0;
        s_in_data  = 16'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_data", $signed(out_data), 32'sd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'sd0);
        chk("rst_abort", {31'd0, frame_abort}, 32'sd0);
        chk("rst_busy", {31'd0, busy}, 32'sd0);
        chk("rst_s_busy", {31'd0, s_busy}, 32'sd0);
        rst_n = 1'b1;
        cyc(1'b0, 0, 0);

        // Constant 1000: 2000 accepted samples
        run_frame(0, 1000);
        wait_result("const1000", 1000);

        // Counter jumps back mid-window
        for (int k = 0; k <= 1500; k++) cyc(1'b1, k, 777);
        chk("abort_busy_before", {31'd0, busy}, 32'sd1);
        cyc(1'b1, 10, 777);
        chk("abort_pulse", {31'd0, frame_abort}, 32'sd1);
        chk("abort_busy", {31'd0, busy}, 32'sd0);
        chk("abort_hold_data", $signed(out_data), 32'sd1000);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 0, 0);
            if (out_valid) pulses++;
            if (k == 0) chk("abort_pulse_end", {31'd0, frame_abort}, 32'sd0);
        end
        chk("abort_no_result", pulses, 32'sd0);

        run_frame(0, -700);
        wait_result("after_abort", -700);

        // Ramp centred on the window mean
        run_frame(1, 0);
        wait_result("ramp", 0);

        // Reset while the divider is running
        run_frame(0, 1234);
        for (int k = 0; k < 10; k++) cyc(1'b0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'sd0);
        chk("midrst_data", $signed(out_data), 32'sd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'sd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 0, 0);
            if (out_valid) pulses++;
        end
        chk("midrst_lost", pulses, 32'sd0);
        chk("midrst_data_after", $signed(out_data), 32'sd0);
        run_frame(0, 250);
        wait_result("after_rst", 250);

        // Random in_valid gaps, most negative sample value
        c = 0;
        for (int g = 0; (g < 30000) && (c < 4096); g++) begin
            if ($urandom_range(0, 1) == 1) begin
                cyc(1'b1, c, -32768);
                c++;
            end else begin
                cyc(1'b0, $urandom_range(0, 4095), 12345);
            end
        end
        wait_result("neg_full", -32768);

        // Short frame: -1,-1,0 -> -2/3
`ifdef VPPM_AVG_ROUND_EN
        exp_small = -1;
`else
        exp_small = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            s_in_valid = 1'b1;
            s_in_count = 13'(k);
            s_in_data  = ((k == 1) || (k == 2)) ? 16'hFFFF : 16'h0000;
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        chk("small_busy", {31'd0, s_busy}, 32'sd1);
        lat = 0;
        for (int k = 1; (k <= 40) && (lat == 0); k++) begin
            @(posedge clk);
            #1;
            if (s_out_valid) lat = k;
        end
        chk("small_latency", lat, 32'sd31);
        chk("small_data", $signed(s_out_data), exp_small);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vppm_window_avg.md
# vppm_window_avg

Parametrised successor to the receiver's single-channel symbol averager. It accumulates signed ADC samples over a configurable counter window, with configurable skip, decimation and frame length, and divides by the runtime count of accepted samples using a sequential divider. It then presents one signed mean per frame with a valid pulse. It sits between the sample-counter/ADC front end and the VPPM slicer/threshold logic.

## Interface
Parameters:
- DW, 16, sample and result width (signed)
- CW, 13, frame counter width
- SKIP, 96, window opens after in_count exceeds SKIP
- FRAME_LEN, 4096, window closes at in_count == FRAME_LEN-1; must satisfy SKIP < FRAME_LEN-1 < 2**CW
- DECIM, 2, accept every DECIM-th valid in-window sample, 1..16

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  qualifies in_count/in_data this cycle
- in_count  in  CW  frame sample index from front end
- in_data  in  DW  signed sample
- out_data  out  DW  signed frame mean, held until next result
- out_valid  out  1  one-cycle pulse when out_data updates
- frame_abort  out  1  one-cycle pulse when a frame is discarded
- busy  out  1  high in ACC and DIV

## Operation
- Internal widths: AW = DW+CW accumulator (signed), CW-bit accepted-sample counter n, phase counter 0..DECIM-1.
- States:
  - IDLE: acc=0, n=0, phase=0. On in_valid && in_count > SKIP, go to ACC; this sample is processed as an ACC sample in the same cycle.
  - ACC: on each in_valid sample, accept it if phase==0 (acc+=in_data, n+=1); phase = (phase+1) mod DECIM. A valid sample with in_count == FRAME_LEN-1 (accepted or not) goes to DIV.
  - DIV: starts the divider with acc/n. When the divider signals done, load out_data, pulse out_valid and go to HOLD.
  - HOLD: on in_valid && in_count == 0, go to IDLE.
- Abort: in ACC, a valid sample whose in_count is less than or equal to the previous valid in_count (frame restart or counter wrap) goes to IDLE, pulses frame_abort and produces no output. The aborting sample is not accumulated.
- Division: signed, quotient truncated toward zero. If n==0, the result is 0 and no divide is run, but the result still takes the full DIV latency.
- Result: the quotient is clamped to the signed DW range before loading out_data.
- in_valid low: no state change in any state except DIV, whose progress is independent of in_valid.
- Samples arriving during DIV and HOLD are ignored.

## Timing
- Reset values: out_data=0, out_valid=0, frame_abort=0, busy=0, state IDLE, acc/n/phase=0.
- Reset mid-operation: everything returns to reset values immediately; a pending result is lost.
- out_valid rises exactly AW+2 clock edges after the edge that samples the in_count==FRAME_LEN-1 sample.
- out_data changes only on the edge that raises out_valid.
- frame_abort rises on the edge after the offending sample.
- busy is registered: high from the IDLE→ACC edge until the out_valid edge.

## Configuration
- VPPM_AVG_ROUND_EN defined: round half away from zero. Add n>>1 to |acc| before dividing, then reapply the sign.
- VPPM_AVG_ROUND_EN undefined: truncate toward zero.
- Latency is identical in both builds.

## Structure
- Package vppm_avg_pkg holds:
  - state enum {IDLE, ACC, DIV, HOLD}
  - function computing AW
  - localparam limits for the DW clamp
- Sub-module vppm_seq_div: unsigned restoring divider, AW-bit dividend, CW-bit divisor, start/done, exactly AW cycles. Sign handling and rounding stay in the parent.

## Test plan
- Defaults, in_data=1000 constant, counts 0..4095 with in_valid high -> n=2000 (counts 97,99,…,4095), out_data=1000, out_valid AW+2 edges after count 4095.
- Defaults, in_data = in_count-2096 -> out_data=0 in both builds.
- SKIP=0, FRAME_LEN=4, DECIM=1, data -1,-1,0 at counts 1..3 -> out_data=0 without VPPM_AVG_ROUND_EN, -1 with it.
- Defaults, in_count jumps 1500→10 during ACC -> frame_abort pulse, no out_valid, previous out_data held. Next frame completes normally.
- Defaults, rst_n low for 1 cycle during DIV -> all outputs 0, state IDLE. Next full frame gives the correct mean.
- in_valid toggled 50% randomly through a frame, data constant -32768 -> out_data=-32768 and no overflow.
